// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage and its consumers in ID:
// reset/exception addresses, the NOP encoding and the IF/ID bundle.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;
    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears the slot even under stall, stall holds it,
// otherwise it captures the fetched word (NOP-ed and tagged when the PC is misaligned).
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_rdata,
    output if_id_t      id
);

    logic aligned;

    assign aligned = (if_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            id.valid <= 1'b0;
            id.pc    <= 32'h0;
            id.inst  <= NOP_WORD;
            id.adel  <= 1'b0;
        end else if (flush) begin
            // PC is left as-is; a flushed slot is invalid so its PC is never consumed
            id.valid <= 1'b0;
            id.inst  <= NOP_WORD;
            id.adel  <= 1'b0;
        end else if (!stall) begin
            id.valid <= if_valid;
            id.pc    <= if_pc;
            id.adel  <= if_valid & ~aligned;
            id.inst  <= (if_valid & aligned) ? if_rdata : NOP_WORD;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, picks the next fetch address,
// drives the synchronous instruction SRAM and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_flush,
    input  logic        eret_flush,
    input  logic [31:0] epc,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adel
);

    logic [31:0] pc;
    logic [31:0] nxt_pc;
    logic        if_valid;
    if_id_t      id_q;

    // Stalling re-requests pc so the SRAM keeps returning the held word;
    // a branch under stall waits because ID keeps br_taken asserted.
    always_comb begin
        nxt_pc = pc + 32'd4;
        if (exc_flush)       nxt_pc = EXC_VECTOR;
        else if (eret_flush) nxt_pc = epc;
        else if (stall)      nxt_pc = pc;
        else if (br_taken)   nxt_pc = br_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC - 32'd4;
            if_valid <= 1'b0;
        end else begin
            pc       <= nxt_pc;
            if_valid <= 1'b1;
        end
    end

    assign inst_sram_en    = ~reset;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = {nxt_pc[31:2], 2'b00};
    assign inst_sram_wdata = 32'h0;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .flush    (exc_flush | eret_flush),
        .if_valid (if_valid),
        .if_pc    (pc),
        .if_rdata (inst_sram_rdata),
        .id       (id_q)
    );

    assign id_valid = id_q.valid;
    assign id_pc    = id_q.pc;
    assign id_inst  = id_q.inst;
    assign id_adel  = id_q.adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the SRAM model returns addr ^ 32'h1111_1111
// one cycle after each enabled request.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_flush;
    logic        eret_flush;
    logic [31:0] epc;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    int vectorCount = 0;
    int errorCount  = 0;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .exc_flush       (exc_flush),
        .eret_flush      (eret_flush),
        .epc             (epc),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_adel         (id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ 32'h1111_1111;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt,
                                 input logic exc, input logic eret, input logic [31:0] ep);
        stall      = st;
        br_taken   = br;
        br_target  = tgt;
        exc_flush  = exc;
        eret_flush = eret;
        epc        = ep;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkIfId(input string tag, input logic v, input logic [31:0] p,
                             input logic [31:0] i, input logic a);
        checkOutput({tag, "_valid"}, 32'(id_valid), 32'(v));
        checkOutput({tag, "_pc"},    id_pc, p);
        checkOutput({tag, "_inst"},  id_inst, i);
        checkOutput({tag, "_adel"},  32'(id_adel), 32'(a));
    endtask

    initial begin
        inst_sram_rdata = 32'h0;
        reset = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();
        checkOutput("rst_en", 32'(inst_sram_en), 32'd0);
        checkIfId("rst", 0, 32'h0, 32'h0, 0);

        // Reset release and sequential fetch
        reset = 1'b0;
        #1;
        checkOutput("c0_en", 32'(inst_sram_en), 32'd1);
        checkOutput("c0_addr", inst_sram_addr, 32'hBFC0_0000);
        checkOutput("wen", 32'(inst_sram_wen), 32'd0);
        checkOutput("wdata", inst_sram_wdata, 32'h0);
        tick();
        checkOutput("c1_addr", inst_sram_addr, 32'hBFC0_0004);
        checkOutput("c1_valid", 32'(id_valid), 32'd0);
        tick();
        checkIfId("c2", 1, 32'hBFC0_0000, 32'hAED1_1111, 0);
        checkOutput("c2_addr", inst_sram_addr, 32'hBFC0_0008);
        tick();
        checkIfId("c3", 1, 32'hBFC0_0004, 32'hAED1_1115, 0);
        tick();
        checkOutput("c4_idpc", id_pc, 32'hBFC0_0008);
        checkOutput("c4_addr", inst_sram_addr, 32'hBFC0_0010);

        // Branch in ID at BFC00008: delay slot then target, no bubble
        applyStimulus(0, 1, 32'hBFC0_0100, 0, 0, 32'h0);
        checkOutput("br_addr", inst_sram_addr, 32'hBFC0_0100);
        tick();
        checkIfId("br_ds", 1, 32'hBFC0_000C, 32'hAED1_111D, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        checkIfId("br_tgt", 1, 32'hBFC0_0100, 32'hAED1_1011, 0);
        checkOutput("br_next", inst_sram_addr, 32'hBFC0_0108);

        // Stall for 3 cycles with a pending branch
        applyStimulus(1, 1, 32'hBFC0_0200, 0, 0, 32'h0);
        checkOutput("st_addr0", inst_sram_addr, 32'hBFC0_0104);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("st_addr", inst_sram_addr, 32'hBFC0_0104);
            checkOutput("st_idpc", id_pc, 32'hBFC0_0100);
            checkOutput("st_inst", id_inst, 32'hAED1_1011);
        end
        applyStimulus(0, 1, 32'hBFC0_0200, 0, 0, 32'h0);
        checkOutput("st_redir", inst_sram_addr, 32'hBFC0_0200);
        tick();
        checkIfId("st_rel", 1, 32'hBFC0_0104, 32'hAED1_1015, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("st_after", inst_sram_addr, 32'hBFC0_0204);

        // Exception flush beats stall: one bubble, then the vector
        applyStimulus(1, 0, 32'h0, 1, 0, 32'h0);
        checkOutput("exc_addr", inst_sram_addr, 32'hBFC0_0380);
        tick();
        checkIfId("exc_bub", 0, 32'hBFC0_0104, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        checkIfId("exc_vec", 1, 32'hBFC0_0380, 32'hAED1_1291, 0);

        // Exception and eret together: exception vector wins
        applyStimulus(0, 0, 32'h0, 1, 1, 32'h8000_1000);
        checkOutput("both_addr", inst_sram_addr, 32'hBFC0_0380);
        tick();
        checkOutput("both_valid", 32'(id_valid), 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        checkOutput("both_idpc", id_pc, 32'hBFC0_0380);

        // Misaligned eret target: aligned request, NOP tagged with adel
        applyStimulus(0, 0, 32'h0, 0, 1, 32'h8000_1002);
        checkOutput("eret_addr", inst_sram_addr, 32'h8000_1000);
        tick();
        checkOutput("eret_bub", 32'(id_valid), 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("eret_next", inst_sram_addr, 32'h8000_1004);
        tick();
        checkIfId("eret_adel", 1, 32'h8000_1002, 32'h0, 1);

        // Reset mid-stream
        reset = 1'b1;
        #1;
        checkOutput("mrst_en0", 32'(inst_sram_en), 32'd0);
        tick();
        checkIfId("mrst", 0, 32'h0, 32'h0, 0);
        tick();
        checkOutput("mrst_en", 32'(inst_sram_en), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mrst_addr", inst_sram_addr, 32'hBFC0_0000);
        tick();
        tick();
        checkIfId("mrst_rel", 1, 32'hBFC0_0000, 32'hAED1_1111, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline, placed directly upstream of `decode`. It owns the PC, computes the next fetch address, drives the synchronous instruction SRAM, and registers each returned word with its PC into the IF/ID register. That register feeds `decode.instruction` and the ID-stage datapath. It applies stalls, delay-slot branch redirects, exception and `eret` redirects, and fetch address-error tagging.

## Interface
Parameters:
- `RESET_PC`, default 32'hBFC0_0000: first fetched address after reset.
- `EXC_VECTOR`, default 32'hBFC0_0380: redirect target on exception flush.

Ports:
- `clk`  in  1  : the single clock. All state updates on its rising edge.
- `reset`  in  1  : synchronous, active-high.
- `stall`  in  1  : ID stage cannot accept. Hold the PC and the IF/ID register.
- `br_taken`  in  1  : taken branch or jump resolved in ID.
- `br_target`  in  32  : target address for `br_taken`.
- `exc_flush`  in  1  : exception committed. Redirect to `EXC_VECTOR`.
- `eret_flush`  in  1  : `eret` committed. Redirect to `epc`.
- `epc`  in  32  : CP0 EPC value.
- `inst_sram_en`  out  1  : SRAM read enable.
- `inst_sram_wen`  out  4  : tied to 4'b0000.
- `inst_sram_addr`  out  32  : word-aligned fetch address.
- `inst_sram_wdata`  out  32  : tied to 0.
- `inst_sram_rdata`  in  32  : read data, valid one cycle after the address.
- `id_valid`  out  1  : IF/ID register holds a real instruction.
- `id_pc`  out  32  : PC of the instruction in IF/ID.
- `id_inst`  out  32  : instruction to `decode`. Forced to 0 (NOP) when invalid.
- `id_adel`  out  1  : the instruction in IF/ID had a misaligned fetch PC.

## Operation
- State registers:
  - `pc`: address whose SRAM data is on `inst_sram_rdata` this cycle.
  - `if_valid`
  - IF/ID register: `id_valid`, `id_pc`, `id_inst`, `id_adel`.
- `nxt_pc` is combinational. Priority, highest first:
  - `exc_flush` → `EXC_VECTOR`
  - `eret_flush` → `epc`
  - `stall` → `pc` (re-requests the same word, so `rdata` stays valid)
  - `br_taken` → `br_target`
  - otherwise `pc + 4` (mod 2^32, wraps silently)
- SRAM drive:
  - `inst_sram_en = ~reset`.
  - `inst_sram_addr = {nxt_pc[31:2], 2'b00}`.
- Every non-reset edge:
  - `pc <= nxt_pc`.
  - `if_valid <= 1`.
- Delay slot: a branch in ID sees its delay slot in IF at `pc`. Redirecting `nxt_pc` therefore executes the delay slot naturally. No extra squash is applied on branch.
- Stall beats branch. The stalled branch keeps `br_taken` asserted until the stall releases, so no branch state is stored here.
- IF/ID update, in priority order:
  - `exc_flush` or `eret_flush` → `id_valid <= 0`, `id_inst <= 0`, `id_adel <= 0`. This applies even if `stall` is asserted.
  - else `stall` → hold all IF/ID fields.
  - else:
    - `id_valid <= if_valid`
    - `id_pc <= pc`
    - `id_adel <= if_valid & (pc[1:0] != 0)`
    - `id_inst <= (if_valid & pc[1:0] == 0) ? inst_sram_rdata : 0`
- Address error: a misaligned `br_target` or `epc` still issues an aligned SRAM request. The instruction reaches ID as a NOP with `id_adel=1`, and the exception logic downstream takes it.

## Timing
- Reset values:
  - `pc = RESET_PC - 4`, `if_valid = 0`.
  - `id_valid = 0`, `id_pc = 0`, `id_inst = 0`, `id_adel = 0`.
  - `inst_sram_en = 0`.
- Reset asserted mid-operation discards all in-flight fetches at that edge. There is no partial state.
- Cycle 0 after reset deasserts: request `RESET_PC`.
- Cycle 1: `pc = RESET_PC`, `if_valid = 1`.
- Cycle 2: `id_pc = RESET_PC`, `id_valid = 1`.
- Fetch-to-ID latency: 2 cycles. Throughput: 1 instruction per cycle when unstalled.
- Redirect penalty:
  - Branch: 0 bubbles (delay slot fills the gap).
  - Flush: exactly 1 bubble (`id_valid=0`), then the vector instruction.
- `exc_flush` and `eret_flush` asserted together: `exc_flush` wins.

## Structure
- Shared CPU package holds:
  - `RESET_PC` and `EXC_VECTOR` defaults
  - `NOP_WORD = 32'h0000_0000`
  - an IF/ID bundle typedef (`valid`, `pc`, `inst`, `adel`), reused by the ID stage
- One natural sub-module: `if_id_reg`, holding the IF/ID register with its hold and flush logic. PC and next-PC logic stay in `fetch_stage`.

## Test plan
- Reset release, SRAM returns `addr ^ 32'h1111_1111`:
  - requests run BFC00000, BFC00004, …
  - `id_pc = BFC00000` with `id_valid=1` two cycles after reset.
- `br_taken=1`, `br_target=BFC00100` while branch PC is BFC00008:
  - IF/ID carries BFC0000C (delay slot), then BFC00100.
  - No `id_valid` gap.
- `stall` held 3 cycles, plus simultaneous `br_taken`:
  - `inst_sram_addr`, `id_pc` and `id_inst` are frozen for all 3 cycles.
  - The redirect to `br_target` occurs on the first unstalled cycle.
- `exc_flush` pulse with `stall=1`:
  - next cycle `id_valid=0`, `id_inst=0`.
  - the following cycle `id_pc=BFC00380`.
  - `exc_flush` with `eret_flush`, `epc=80001000`: vector BFC00380 is chosen.
- `eret_flush` with `epc=80001002`:
  - IF/ID shows `id_pc=80001002`, `id_adel=1`, `id_inst=0`.
  - the next request is aligned 80001004.
- Reset asserted mid-stream:
  - all outputs return to their reset values on the following edge.
  - `inst_sram_en=0` while reset is held.
